// File: rtl/sum_trace_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_trace_capture_pkg
// Purpose  : Shared definitions for the sum trace capture block: FSM state
//            encoding and the FIFO pointer-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sum_trace_capture_pkg;

    // Encoding is visible on the state output, so values are fixed.
    typedef enum logic [1:0] {
        ST_ARMED     = 2'd0,
        ST_TRIGGERED = 2'd1,
        ST_FROZEN    = 2'd2
    } state_t;

    // Pointer width for a power-of-two FIFO depth (minimum one bit).
    function automatic int sum_trace_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : sum_trace_capture_pkg
`default_nettype wire

// File: rtl/sum_trace_capture_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with occupancy count. Supports push and pop in
//            the same cycle, including push while full when a pop also occurs.
// Ports    : clk, rst (async, active-high)
//            i_push / i_wdata  - write request and data
//            i_pop             - read acknowledge (head advances)
//            o_rdata           - head entry, forced to 0 while empty
//            o_level           - occupancy 0..DEPTH
//            o_full / o_empty  - status flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sum_trace_capture_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [sum_trace_ptr_width(DEPTH):0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = sum_trace_ptr_width(DEPTH);
    localparam logic [PW-1:0] c_ptr_one = PW'(1);
    localparam logic [PW:0]   c_lvl_one = (PW+1)'(1);
    localparam logic [PW:0]   c_lvl_max = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == c_lvl_max);
    assign o_level = r_level;

    // Pop only real entries; a push into a full FIFO needs a matching pop.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Gating with empty keeps out_data at 0 from reset until the first write
    // without resetting the storage array.
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/sum_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : sum_trace_capture
// Purpose  : Trigger-based trace buffer for the counter-sum adder output.
//            Arms on reset, triggers on the first candidate sample above
//            THRESH, captures POST further samples and freezes. The captured
//            trace drains through a valid/ready port.
// Ports    : clk, rst (async, active-high)
//            in_sum, in_valid  - sample from the adder stage
//            clear             - synchronous re-arm, clears overflow
//            out_data          - {trig_flag, sum} at FIFO head
//            out_valid/out_ready - drain handshake
//            level             - FIFO occupancy
//            state             - ARMED=0, TRIGGERED=1, FROZEN=2
//            overflow          - sticky sample-dropped flag
// Config   : SUM_TRACE_CHANGE_ONLY_EN - when defined, only samples that
//            differ from the previous valid sample are capture candidates.
// Revision : 1.0 - initial release
// ============================================================================
module sum_trace_capture
    import sum_trace_capture_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int DEPTH  = 8,
    parameter int THRESH = 8,
    parameter int POST   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZE-1:0]        in_sum,
    input  logic                   in_valid,
    input  logic                   clear,
    output logic [SIZE:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             state,
    output logic                   overflow
);

    localparam int CW = sum_trace_ptr_width(DEPTH) + 1;
    localparam logic [SIZE-1:0] c_thresh = SIZE'(THRESH);
    localparam logic [CW-1:0]   c_post   = CW'(POST);
    localparam logic [CW-1:0]   c_one    = CW'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_post_cnt;
    logic [CW-1:0]   w_post_nxt;
    logic            r_overflow;
    logic            w_ovf_nxt;

    logic            w_cand;
    logic            w_capture;
    logic            w_room;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_trig_flag;
    logic            w_above;

    // ------------------------------------------------------------------
    // Capture-candidate filter
    // ------------------------------------------------------------------
`ifdef SUM_TRACE_CHANGE_ONLY_EN
    logic [SIZE-1:0] r_last;

    // Tracks every valid sample, even ones that end up dropped or blocked
    // by clear/FROZEN, so the filter always compares against the true
    // previous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
        end else if (in_valid) begin
            r_last <= in_sum;
        end
    end

    assign w_cand = in_valid & (in_sum != r_last);
`else
    assign w_cand = in_valid;
`endif

    assign w_above   = (in_sum > c_thresh);
    assign w_pop     = out_valid & out_ready;
    assign w_capture = w_cand & ~clear & (r_state != ST_FROZEN);
    assign w_room    = ~w_full | w_pop;

    // ------------------------------------------------------------------
    // FSM: next state, post counter, overflow, push decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_post_nxt  = r_post_cnt;
        w_ovf_nxt   = r_overflow;
        w_push      = 1'b0;
        w_trig_flag = 1'b0;

        if (clear) begin
            w_state_nxt = ST_ARMED;
            w_post_nxt  = '0;
            w_ovf_nxt   = 1'b0;
        end else if (w_capture) begin
            w_push = w_room;
            if (!w_room) begin
                w_ovf_nxt = 1'b1;
            end
            case (r_state)
                ST_ARMED: begin
                    // A dropped trigger sample still advances the FSM.
                    if (w_above) begin
                        w_trig_flag = 1'b1;
                        w_post_nxt  = '0;
                        w_state_nxt = (c_post == '0) ? ST_FROZEN : ST_TRIGGERED;
                    end
                end
                ST_TRIGGERED: begin
                    // Only samples actually written count toward POST.
                    if (w_room) begin
                        w_post_nxt = r_post_cnt + c_one;
                        if (w_post_nxt == c_post) begin
                            w_state_nxt = ST_FROZEN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARMED;
            r_post_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_post_cnt <= w_post_nxt;
            r_overflow <= w_ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (SIZE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({w_trig_flag, in_sum}),
        .o_rdata (out_data),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign state     = r_state;
    assign overflow  = r_overflow;

endmodule : sum_trace_capture
`default_nettype wire

// File: tb/tb_sum_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_trace_capture
// Purpose  : Self-checking bench for sum_trace_capture (SIZE=8, DEPTH=8,
//            THRESH=8, POST=3). Table of per-cycle vectors plus hand-written
//            drain, async reset and change-filter sequences.
// Config   : SUM_TRACE_CHANGE_ONLY_EN selects change-filter expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_trace_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_sum;
    logic       in_valid;
    logic       clear;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;
    logic [1:0] state;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SUM_TRACE_CHANGE_ONLY_EN
    localparam logic [7:0] SEC = 8'd21;
`else
    localparam logic [7:0] SEC = 8'd20;
`endif

    sum_trace_capture #(
        .SIZE   (8),
        .DEPTH  (8),
        .THRESH (8),
        .POST   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .state     (state),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic       c;
        logic       r;
        int         el;
        int         es;
        logic       ev;
        logic [8:0] ed;
        logic       eo;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic v, input logic [7:0] s,
                                input logic c, input logic r, input int el,
                                input int es, input logic ev,
                                input logic [8:0] ed, input logic eo);
        vec_t t;
        t.v = v; t.s = s; t.c = c; t.r = r;
        t.el = el; t.es = es; t.ev = ev; t.ed = ed; t.eo = eo;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] s,
                         input logic c, input logic r);
        in_valid  = v;
        in_sum    = s;
        clear     = c;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_sum = '0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [8:0] drain_exp [8];

    initial begin
        // --- Main trace vector table ---
        // Phase A: 1,2,3 held, then drained
        tv.push_back(mk(1, 1, 0, 0, 1, 0, 1, 9'h001, 0));
        tv.push_back(mk(1, 2, 0, 0, 2, 0, 1, 9'h001, 0));
        tv.push_back(mk(1, 3, 0, 0, 3, 0, 1, 9'h001, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 0, 1, 9'h002, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 0, 1, 9'h003, 0));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9'h000, 0));
        // Phase B: trigger on 9, POST=3 more, freeze after 12, 13 ignored
        tv.push_back(mk(1, 5,  0, 0, 1, 0, 1, 9'h005, 0));
        tv.push_back(mk(1, 9,  0, 0, 2, 1, 1, 9'h005, 0));
        tv.push_back(mk(1, 10, 0, 0, 3, 1, 1, 9'h005, 0));
        tv.push_back(mk(1, 11, 0, 0, 4, 1, 1, 9'h005, 0));
        tv.push_back(mk(1, 12, 0, 0, 5, 2, 1, 9'h005, 0));
        tv.push_back(mk(1, 13, 0, 0, 5, 2, 1, 9'h005, 0));
        tv.push_back(mk(0, 0,  0, 1, 4, 2, 1, 9'h109, 0));
        tv.push_back(mk(0, 0,  0, 1, 3, 2, 1, 9'h00A, 0));
        tv.push_back(mk(0, 0,  0, 1, 2, 2, 1, 9'h00B, 0));
        tv.push_back(mk(0, 0,  0, 1, 1, 2, 1, 9'h00C, 0));
        tv.push_back(mk(0, 0,  0, 1, 0, 2, 0, 9'h000, 0));
        // Clear with coincident 20: not captured; next sample triggers
        tv.push_back(mk(1, 20,  1, 0, 0, 0, 0, 9'h000, 0));
        tv.push_back(mk(1, SEC, 0, 0, 1, 1, 1, {1'b1, SEC}, 0));
        tv.push_back(mk(0, 0,   1, 0, 1, 0, 1, {1'b1, SEC}, 0));
        tv.push_back(mk(0, 0,   0, 1, 0, 0, 0, 9'h000, 0));
        // Phase C: fill with alternating 1,2 then overflow
        for (int i = 0; i < 10; i++) begin
            tv.push_back(mk(1, (i % 2 == 0) ? 8'd1 : 8'd2, 0, 0,
                            (i < 8) ? i + 1 : 8, 0, 1, 9'h001, (i >= 8)));
        end
        tv.push_back(mk(0, 0, 1, 0, 8, 0, 1, 9'h001, 0));
        // Full FIFO, pop and push in the same cycle
        tv.push_back(mk(1, 3, 0, 1, 8, 0, 1, 9'h002, 0));

        drain_exp = '{9'h002, 9'h001, 9'h002, 9'h001,
                      9'h002, 9'h001, 9'h002, 9'h003};

        do_reset();

        // Reset state
        chk("reset_level", int'(level), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        chk("reset_ovf", int'(overflow), 0);

        foreach (tv[k]) begin
            drive(tv[k].v, tv[k].s, tv[k].c, tv[k].r);
            chk($sformatf("v%0d_level", k), int'(level), tv[k].el);
            chk($sformatf("v%0d_state", k), int'(state), tv[k].es);
            chk($sformatf("v%0d_valid", k), int'(out_valid), int'(tv[k].ev));
            if (tv[k].ev) begin
                chk($sformatf("v%0d_data", k), int'(out_data), int'(tv[k].ed));
            end
            chk($sformatf("v%0d_ovf", k), int'(overflow), int'(tv[k].eo));
        end

        // Drain remaining full FIFO, checking order and level
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_data", i), int'(out_data), int'(drain_exp[i]));
            drive(1'b0, 8'd0, 1'b0, 1'b1);
            chk($sformatf("drain%0d_level", i), int'(level), 7 - i);
        end
        chk("drain_valid", int'(out_valid), 0);

        // Asynchronous reset mid-trace discards entries without a clock edge
        drive(1'b1, 8'd5, 1'b0, 1'b0);
        drive(1'b1, 8'd6, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("pre_arst_level", int'(level), 2);
        rst = 1'b1;
        #2;
        chk("arst_level", int'(level), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Change filter: 4,4,4,7
        drive(1'b1, 8'd4, 1'b0, 1'b0);
        drive(1'b1, 8'd4, 1'b0, 1'b0);
        drive(1'b1, 8'd4, 1'b0, 1'b0);
        drive(1'b1, 8'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
`ifdef SUM_TRACE_CHANGE_ONLY_EN
        chk("chg_level", int'(level), 2);
`else
        chk("chg_level", int'(level), 4);
`endif
        chk("chg_head", int'(out_data), 9'h004);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        chk("chg_second", int'(out_data), 9'h004 + 9'h003 *
`ifdef SUM_TRACE_CHANGE_ONLY_EN
            1
`else
            0
`endif
        );

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_sum_trace_capture
`default_nettype wire

// File: doc/sum_trace_capture.md
# sum_trace_capture

Trigger-based trace buffer that sits directly downstream of the counter-sum adder. It samples the SIZE-bit sum each `clk` cycle while `in_valid` is high and stores samples in a small FIFO. It arms on reset, triggers when the sum exceeds THRESH, records POST further samples and then freezes. The captured trace is drained through a valid/ready port so a monitor or debug interface can inspect the behaviour around the threshold reset.

## Interface
- SIZE, 8: sum width in bits.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- THRESH, 8: trigger threshold; a sample triggers when in_sum > THRESH (unsigned).
- POST, 3: samples captured after the trigger sample; range 0..DEPTH-1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_sum  input  SIZE  sum from the adder stage.
- in_valid  input  1  in_sum is a sample this cycle.
- clear  input  1  synchronous re-arm; also clears overflow.
- out_data  output  SIZE+1  {trig_flag, sum} at the FIFO head; trig_flag=1 only on the trigger sample.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- state  output  2  ARMED=0, TRIGGERED=1, FROZEN=2.
- overflow  output  1  sticky; a sample was dropped because the FIFO was full.

## Operation
- FSM states:
  - ARMED: every valid sample is a capture candidate. A candidate with in_sum > THRESH is written with trig_flag=1; the FSM goes to TRIGGERED with post_cnt=0. If POST=0, it goes straight to FROZEN.
  - TRIGGERED: valid samples are written with trig_flag=0. Each written sample increments post_cnt. When post_cnt reaches POST, the FSM goes to FROZEN on that same edge. Samples above THRESH in this state do not retrigger.
  - FROZEN: no samples are written. Draining continues. `clear` returns the FSM to ARMED.
- `clear` has priority over capture. A sample arriving in the same cycle as `clear` is not written. `clear` moves any state to ARMED, zeroes post_cnt and clears overflow. The FIFO contents are not flushed.
- Push/pop:
  - A pop happens when out_valid & out_ready.
  - A push happens on a capture candidate when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - A candidate that arrives while the FIFO is full with no pop is dropped. The drop sets overflow. A dropped sample does not count toward post_cnt. A dropped trigger sample still causes the FSM transition.
- Arithmetic:
  - Comparisons are unsigned at SIZE bits.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level saturates naturally because it cannot exceed DEPTH.
- Reset values: state=ARMED, level=0, out_valid=0, overflow=0, out_data=0, pointers=0, post_cnt=0. FIFO storage needs no reset.
- Reset asserted mid-trace discards all entries immediately.

## Timing
- Write latency: a sample captured at edge N is visible on out_data with out_valid=1 after edge N. There is no bypass from in_sum to out_data.
- Pop: out_data advances to the next entry after the accepting edge. out_valid drops after the edge that pops the last entry, unless a push occurs in the same cycle.
- Simultaneous push and pop leaves level unchanged, including at level=DEPTH and at level=0 (the latter only when the entry being popped was already present).
- The state transition and the write of the causing sample take effect on the same edge.
- out_data is don't-care while out_valid=0, but it is driven 0 from reset until the first write.

## Configuration
- `SUM_TRACE_CHANGE_ONLY_EN`:
  - Defined: a valid sample is a capture candidate only if in_sum differs from the last valid sample seen. Trigger evaluation uses candidates only. The last-value register resets to 0 and updates on every valid sample, including dropped ones.
  - Undefined: every valid sample is a candidate, and the last-value register is not built.

## Structure
- The shared package holds:
  - the state encoding typedef (ARMED, TRIGGERED, FROZEN);
  - a helper computing pointer width from DEPTH.
- One natural sub-module, `sync_fifo`, provides storage, pointers, level, full/empty and simultaneous push/pop. The top level holds the FSM, post counter, trigger compare, change filter and overflow.

## Test plan
- Reset, then valid sums 1,2,3 with out_ready=0 -> level=3, state=ARMED, out_data={0,1}.
- SIZE=8, THRESH=8, POST=3, sums 5,9,10,11,12,13 -> state=FROZEN after sum 12. The FIFO holds 5,{1,9},10,11,12, and 13 is not captured.
- DEPTH=4, out_ready=0, 6 valid sums below THRESH -> level=4, overflow=1. Asserting clear -> overflow=0, and level stays 4.
- Full FIFO with out_ready=1 and a valid sample on the same cycle -> the sample is accepted, level stays DEPTH, and overflow stays 0.
- While FROZEN, drain all entries then pulse clear together with sum 20 -> 20 is not captured, state=ARMED. The next sum 20 triggers.
- With `SUM_TRACE_CHANGE_ONLY_EN`, sums 4,4,4,7 -> only 4 and 7 are captured, level=2.
